// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam logic [13:0] DEFAULT_BAUD_DIV = 14'd867;
    localparam logic [13:0] MIN_BAUD_DIV     = 14'd2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP1,
        STOP2
    } rx_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       parity_err;
        logic       frame_err;
    } uart_frame_t;

    // A divisor below 2 leaves no room for a mid-bit sample, so it is raised to 2.
    function automatic logic [13:0] clamp_div(input logic [13:0] div);
        return (div < MIN_BAUD_DIV) ? MIN_BAUD_DIV : div;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO for UART frames; the head is visible without a pop
// and reads back as all zeros while the FIFO is empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  uart_frame_t wr_frame,
    output uart_frame_t rd_frame,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    uart_frame_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_frame;
        end
    end

    assign rd_frame = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: input synchronizer, mid-bit sampling FSM and a frame FIFO.
// Define UART_RX_PARITY_EN to receive and check a parity bit after the data.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_in,
    input  logic        rx_en,
    input  logic [13:0] baud_divisor,
    input  logic        two_stop,
    input  logic        odd_parity,
    input  logic        rd_en,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP1;
`endif

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxs;
    logic                   rxs_prev_reg;
    logic                   fall;

    rx_state_t   state_reg;
    rx_state_t   state_next;
    logic [13:0] cnt_reg;
    logic [13:0] cnt_next;
    logic [2:0]  bit_reg;
    logic [2:0]  bit_next;
    logic [7:0]  data_reg;
    logic [7:0]  data_next;
    logic        ferr_reg;
    logic        ferr_next;
    logic [13:0] div_reg;
    logic [13:0] half_div;
    logic        two_stop_reg;
    logic        latch_cfg;
    logic        push;
    logic        bit_tick;
    uart_frame_t push_frame;
    uart_frame_t head_frame;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overrun_reg;

`ifdef UART_RX_PARITY_EN
    logic        odd_reg;
    logic        perr_reg;
    logic        perr_next;
`else
    logic        unused_odd_parity;
    assign unused_odd_parity = odd_parity;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '1;
        end else begin
            sync_reg[0] <= rx_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign rxs      = sync_reg[SYNC_STAGES-1];
    assign fall     = rxs_prev_reg & ~rxs;
    assign half_div = {1'b0, div_reg[13:1]};
    assign bit_tick = (cnt_reg == div_reg);

    // Line settings are frozen at the start edge so a mid-frame change cannot corrupt it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg      <= DEFAULT_BAUD_DIV;
            two_stop_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            odd_reg      <= 1'b0;
`endif
        end else if (latch_cfg) begin
            div_reg      <= clamp_div(baud_divisor);
            two_stop_reg <= two_stop;
`ifdef UART_RX_PARITY_EN
            odd_reg      <= odd_parity;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            data_reg     <= '0;
            ferr_reg     <= 1'b0;
            rxs_prev_reg <= 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_reg     <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            data_reg     <= data_next;
            ferr_reg     <= ferr_next;
            rxs_prev_reg <= rxs;
`ifdef UART_RX_PARITY_EN
            perr_reg     <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        data_next  = data_reg;
        ferr_next  = ferr_reg;
        latch_cfg  = 1'b0;
        push       = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_next  = perr_reg;
`endif
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                bit_next = '0;
                if (rx_en && fall) begin
                    state_next = START;
                    latch_cfg  = 1'b1;
                    ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_next  = 1'b0;
`endif
                end
            end
            START: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (cnt_reg == half_div) begin
                    cnt_next   = '0;
                    state_next = rxs ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + 14'd1;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_next  = '0;
                    data_next = {rxs, data_reg[7:1]};
                    bit_next  = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next = AFTER_DATA;
                    end
                end else begin
                    cnt_next = cnt_reg + 14'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    cnt_next   = '0;
                    perr_next  = rxs ^ (odd_reg ? ~^data_reg : ^data_reg);
                    state_next = STOP1;
                end else begin
                    cnt_next = cnt_reg + 14'd1;
                end
            end
`endif
            STOP1: begin
                if (bit_tick) begin
                    cnt_next = '0;
                    if (two_stop_reg) begin
                        ferr_next  = ~rxs;
                        state_next = STOP2;
                    end else begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 14'd1;
                end
            end
            STOP2: begin
                if (bit_tick) begin
                    cnt_next   = '0;
                    push       = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 14'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        if (!rx_en && (state_reg != IDLE)) begin
            state_next = IDLE;
            cnt_next   = '0;
            push       = 1'b0;
        end
    end

    // The final stop sample is folded in directly, so the push needs no extra cycle.
    always_comb begin
        push_frame.data      = data_reg;
`ifdef UART_RX_PARITY_EN
        push_frame.parity_err = perr_reg;
`else
        push_frame.parity_err = 1'b0;
`endif
        push_frame.frame_err = ferr_reg | ~rxs;
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (rd_en),
        .wr_frame (push_frame),
        .rd_frame (head_frame),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_reg <= 1'b0;
        end else if (push && fifo_full && !rd_en) begin
            overrun_reg <= 1'b1;
        end else if (rd_en && !fifo_empty) begin
            overrun_reg <= 1'b0;
        end
    end

    assign rx_data    = head_frame.data;
    assign rx_valid   = ~fifo_empty;
    assign parity_err = head_frame.parity_err;
    assign frame_err  = head_frame.frame_err;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: vector table, hand-built corner sequences and random
// frames against a queue-based model. Follows UART_RX_PARITY_EN like the RTL.
module tb_uart_rx_core;

    localparam int SYNC  = 2;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_in = 1'b1;
    logic        rx_en = 1'b0;
    logic [13:0] baud_divisor = 14'd9;
    logic        two_stop = 1'b0;
    logic        odd_parity = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    logic valid_q = 1'b0;

    typedef struct {
        logic [7:0]  d;
        logic        par;
        logic        s1;
        logic        s2;
        logic        ts;
        logic        odd;
        logic [13:0] div;
        logic        exp_pe;
        logic        exp_fe;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } frame_t;

    frame_t model_q[$];
    logic   model_ovr = 1'b0;

    uart_rx_core #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_in        (rx_in),
        .rx_en        (rx_en),
        .baud_divisor (baud_divisor),
        .two_stop     (two_stop),
        .odd_parity   (odd_parity),
        .rd_en        (rd_en),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !valid_q) rise_cyc <= cyc;
        valid_q <= rx_valid;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    function automatic logic good_par(input logic [7:0] d, input logic odd);
        return odd ? ~^d : ^d;
    endfunction

    function automatic int eff_div(input logic [13:0] div);
        return (div < 14'd2) ? 2 : int'(div);
    endfunction

    // Cycle at which rx_valid is first seen high, counted from the start-bit drive.
    function automatic int exp_rise(input int start_c, input logic [13:0] div, input logic ts);
        int d;
        int nb;
        d  = eff_div(div);
        nb = 10 + PAR_EN + int'(ts);
        return start_c + 1 + SYNC + (d >> 1) + 1 + (nb - 1) * (d + 1);
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic par, input logic s1,
                              input logic s2, input logic ts, input logic odd,
                              input logic [13:0] div, output int start_c);
        int   p;
        logic bits[$];
        p = eff_div(div) + 1;
        baud_divisor = div;
        two_stop = ts;
        odd_parity = odd;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (PAR_EN != 0) bits.push_back(par);
        bits.push_back(s1);
        if (ts) bits.push_back(s2);
        start_c = cyc;
        foreach (bits[i]) begin
            rx_in = bits[i];
            repeat (p) @(negedge clk);
        end
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_read();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_parity_err"}, parity_err, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_head(input string tag);
        check({tag, "_valid"}, rx_valid, (model_q.size() > 0) ? 1 : 0);
        check({tag, "_overrun"}, overrun, model_ovr);
        if (model_q.size() > 0) begin
            check({tag, "_data"}, rx_data, model_q[0].d);
            check({tag, "_pe"}, parity_err, model_q[0].pe);
            check({tag, "_fe"}, frame_err, model_q[0].fe);
        end else begin
            check({tag, "_data_empty"}, rx_data, 0);
        end
    endtask

    task automatic model_read();
        do_read();
        if (model_q.size() > 0) begin
            void'(model_q.pop_front());
            model_ovr = 1'b0;
        end
    endtask

    initial begin
        vec_t   vecs[8];
        int     sc;
        int     x;
        logic   saw;
        logic [7:0]  d;
        logic        odd;
        logic        ts;
        logic        par;
        logic        s1;
        logic        s2;
        logic [13:0] div;
        frame_t      f;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'd9,  1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 14'd9,  1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 14'd9,  1'b0, 1'b1};
        vecs[3] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'd12, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14'd7,  1'b0, 1'b1};
        vecs[5] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 14'd1,  1'b0, 1'b0};
        vecs[6] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14'd6,  1'b0, 1'b1};
        vecs[7] = '{8'hFE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 14'd15, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        rx_en = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            send_frame(vecs[i].d, vecs[i].par, vecs[i].s1, vecs[i].s2, vecs[i].ts,
                       vecs[i].odd, vecs[i].div, sc);
            check($sformatf("vec%0d_latency", i), rise_cyc,
                  exp_rise(sc, vecs[i].div, vecs[i].ts));
            check($sformatf("vec%0d_valid", i), rx_valid, 1);
            check($sformatf("vec%0d_data", i), rx_data, vecs[i].d);
            check($sformatf("vec%0d_pe", i), parity_err, vecs[i].exp_pe & (PAR_EN != 0));
            check($sformatf("vec%0d_fe", i), frame_err, vecs[i].exp_fe);
            do_read();
            check($sformatf("vec%0d_empty_valid", i), rx_valid, 0);
            check($sformatf("vec%0d_empty_data", i), rx_data, 0);
        end

        // 3-cycle low glitch must start a frame and then abandon it.
        baud_divisor = 14'd9;
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rx_in = (i < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (busy) saw = 1'b1;
        end
        check("glitch_seen_busy", saw, 1);
        check("glitch_idle", busy, 0);
        check("glitch_no_push", rx_valid, 0);

        // Five frames into a four-deep FIFO.
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), good_par(8'(k), 1'b0), 1'b1, 1'b1, 1'b0, 1'b0, 14'd9, sc);
        end
        check("ovr_set", overrun, 1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ovr_read%0d", k), rx_data, k);
            do_read();
            if (k == 1) check("ovr_cleared", overrun, 0);
        end
        check("ovr_drained", rx_valid, 0);

        // Full FIFO with a read in the exact cycle of the push.
        for (int k = 1; k <= 4; k++) begin
            send_frame(8'h10 + 8'(k), good_par(8'h10 + 8'(k), 1'b0), 1'b1, 1'b1, 1'b0, 1'b0, 14'd9, sc);
        end
        check("full_no_ovr", overrun, 0);
        x = SYNC + (9 >> 1) + 1 + (10 + PAR_EN - 1) * 10;
        fork
            send_frame(8'h15, good_par(8'h15, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0, 14'd9, sc);
            begin
                repeat (x) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        check("pushpop_no_ovr", overrun, 0);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("pushpop_read%0d", k), rx_data, 8'h10 + k);
            do_read();
        end
        check("pushpop_drained", rx_valid, 0);

        // rx_en abort mid-DATA keeps earlier FIFO contents.
        send_frame(8'h9A, good_par(8'h9A, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0, 14'd9, sc);
        fork
            send_frame(8'h5A, good_par(8'h5A, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0, 14'd9, sc);
            begin
                repeat (40) @(negedge clk);
                check("abort_busy_before", busy, 1);
                rx_en = 1'b0;
                @(negedge clk);
                check("abort_idle", busy, 0);
            end
        join
        check("abort_still_idle", busy, 0);
        rx_en = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_kept_valid", rx_valid, 1);
        check("abort_kept_data", rx_data, 8'h9A);
        do_read();
        check("abort_nothing_pushed", rx_valid, 0);

        // Random frames against the queue model, with sparse reads so overruns occur.
        for (int n = 0; n < 30; n++) begin
            d   = 8'($urandom);
            odd = 1'($urandom_range(0, 1));
            ts  = 1'($urandom_range(0, 1));
            par = good_par(d, odd) ^ ($urandom_range(0, 3) == 0);
            s1  = ($urandom_range(0, 4) != 0);
            s2  = ($urandom_range(0, 4) != 0);
            div = 14'($urandom_range(6, 15));
            send_frame(d, par, s1, s2, ts, odd, div, sc);
            f.d  = d;
            f.pe = (PAR_EN != 0) && (par != good_par(d, odd));
            f.fe = !s1 || (ts && !s2);
            if (model_q.size() < DEPTH) model_q.push_back(f);
            else model_ovr = 1'b1;
            for (int r = $urandom_range(0, 2); r > 0; r--) begin
                check_head($sformatf("rnd%0d", n));
                model_read();
            end
        end
        while (model_q.size() > 0) begin
            check_head("drain");
            model_read();
        end
        check_head("drain_end");

        // Asynchronous reset mid-DATA clears everything immediately.
        send_frame(8'h77, good_par(8'h77, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0, 14'd9, sc);
        fork
            send_frame(8'h66, good_par(8'h66, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0, 14'd9, sc);
            begin
                repeat (40) @(negedge clk);
                check("rst_busy_before", busy, 1);
                check("rst_valid_before", rx_valid, 1);
                rst_n = 1'b0;
                #1;
                check_all_zero("rst_async");
            end
        join
        check_all_zero("rst_held");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_after_busy", busy, 0);
        check("rst_after_valid", rx_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the receive FIFO depth in frames (power of two, minimum 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of rx input synchronizer flops.
REQ-003 clk  in  1  single clock; all state is updated on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 rx_in  in  1  serial line; idle high.
REQ-006 rx_en  in  1  receiver enable.
REQ-007 baud_divisor  in  14  bit period minus one, in clk cycles (867 gives 115200 baud at 100 MHz).
REQ-008 two_stop  in  1  1 selects two stop bits.
REQ-009 odd_parity  in  1  1 selects odd parity, 0 selects even parity.
REQ-010 rd_en  in  1  pops the FIFO head.
REQ-011 rx_data  out  8  FIFO head data (show-ahead).
REQ-012 rx_valid  out  1  FIFO is not empty.
REQ-013 parity_err  out  1  parity-error flag of the FIFO head.
REQ-014 frame_err  out  1  stop-bit-error flag of the FIFO head.
REQ-015 overrun  out  1  sticky flag; a frame was dropped because the FIFO was full.
REQ-016 busy  out  1  FSM is not in IDLE.

Function
REQ-017 rx_in SHALL pass through a SYNC_STAGES-flop synchronizer reset to 1; all sampling uses the synchronized value rxs.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-019 IDLE->START SHALL occur on an rxs 1->0 edge while rx_en=1; baud_divisor, two_stop and odd_parity SHALL be latched at that edge and held for the whole frame.
REQ-020 A latched divisor below 2 SHALL be treated as 2.
REQ-021 Bit counter D SHALL count 0..D (D+1 cycles per bit) and restart at 0 on every sample.
REQ-022 START SHALL sample rxs when the counter reaches D>>1: rxs=0 -> DATA; rxs=1 -> IDLE (glitch), with nothing pushed.
REQ-023 DATA SHALL take 8 samples, one every D+1 cycles, LSB first.
REQ-024 Next state after DATA SHALL be PARITY when parity is compiled in (REQ-035), else STOP1.
REQ-025 Parity error SHALL be set when the received parity bit differs from ^data (even) or ~^data (odd).
REQ-026 STOP1 sample of 0 SHALL set frame_err; with two_stop=1 the FSM SHALL go to STOP2, and a STOP2 sample of 0 SHALL also set frame_err.
REQ-027 On the final stop sample the frame {data, parity_err, frame_err} SHALL be pushed in the same cycle and the FSM SHALL return to IDLE; rx_valid rises on the next cycle.
REQ-028 A push while the FIFO is full SHALL drop the frame and set overrun; a push and rd_en in the same cycle while full SHALL both take effect with no overrun.
REQ-029 overrun SHALL clear on the first accepted rd_en after it is set.
REQ-030 rd_en while the FIFO is empty SHALL be ignored.
REQ-031 rx_data, parity_err and frame_err SHALL be 0 when the FIFO is empty.
REQ-032 rx_en=0 during a frame SHALL abort it: the FSM returns to IDLE next cycle, nothing is pushed, and FIFO contents are kept.

Reset
REQ-033 While rst_n=0: FSM=IDLE, counters=0, FIFO empty, synchronizer=1.
REQ-034 While rst_n=0 all outputs SHALL be 0 (rx_data=8'h00, rx_valid, parity_err, frame_err, overrun and busy all 0). A reset mid-frame discards the frame immediately.

Configuration
REQ-035 Macro UART_RX_PARITY_EN defined: the PARITY state exists and parity_err operates per REQ-025.
REQ-036 Macro UART_RX_PARITY_EN undefined: the PARITY state is removed, odd_parity is ignored, the frame is start+8 data+stop(s), and parity_err is tied to 0.

Structure
REQ-037 Shared package uart_pkg SHALL hold the FSM state enum, the frame struct {data, parity_err, frame_err}, and the constant DEFAULT_BAUD_DIV=867.
REQ-038 The FIFO SHALL be a separate sub-module, uart_rx_fifo (synchronous, show-ahead, full/empty flags).

Verification
REQ-039 Divisor 9, parity on, even parity, one stop; send 0xA5 (parity bit 0) -> rx_valid rises 1 cycle after the stop sample, rx_data=0xA5, both error flags 0.
REQ-040 Odd parity, send 0x3C with parity bit 0 -> parity_err=1, rx_data=0x3C.
REQ-041 two_stop=1, send 0x55 with second stop bit driven 0 -> frame_err=1.
REQ-042 Low pulse of 3 cycles on rx_in with divisor 9 -> FSM returns to IDLE and nothing is pushed.
REQ-043 Send 5 frames 0x01..0x05 with no reads, FIFO_DEPTH=4 -> overrun=1 and reads return 0x01..0x04; simultaneous push and pop while full -> no overrun.
REQ-044 Deassert rx_en or rst_n mid-DATA -> FSM returns to IDLE; on rst_n all outputs are 0; on rx_en abort earlier FIFO entries are intact.
